// File: rtl/gw_video_pkg.sv
// Shared video-pipeline types and sizes.
// Segment ID width/count are common with the mask block.
package gw_video_pkg;

  localparam int SEGMENT_ID_WIDTH = 10;
  localparam int SEGMENT_COUNT    = 1024;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    DRAIN
  } segment_state_t;

  typedef struct packed {
    logic [SEGMENT_ID_WIDTH-1:0] id;
    logic                        value;
  } seg_wr_t;

  localparam int SEG_WR_W = $bits(seg_wr_t);

endpackage

// File: rtl/segment_write_fifo.sv
// Synchronous first-word-fall-through FIFO for queued segment writes.
// Push is accepted when not full, or when full and popping this cycle.
module segment_write_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/segment_state.sv
// Per-pixel segment lit lookup with a 1024x1 state RAM.
// CPU writes are queued and applied in vblank (or when the queue fills).
module segment_state
  import gw_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        seg_wr,
  input  logic [SEGMENT_ID_WIDTH-1:0] seg_wr_id,
  input  logic                        seg_wr_value,
  input  logic                        vblank,
  input  logic [SEGMENT_ID_WIDTH-1:0] segment_id,
  input  logic                        has_segment,
  output logic                        pixel_on,
  output logic                        clearing,
  output logic                        forced_drain,
  output logic                        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SEGMENT_ID_WIDTH-1:0] LAST_ID =
    SEGMENT_ID_WIDTH'(SEGMENT_COUNT - 1);

  segment_state_t state_q;
  segment_state_t state_d;

  logic [SEGMENT_ID_WIDTH-1:0] clr_cnt_q;
  logic [SEGMENT_ID_WIDTH-1:0] clr_cnt_d;

  seg_wr_t        fifo_wdata;
  seg_wr_t        fifo_rdata;
  logic [SEG_WR_W-1:0] fifo_rdata_raw;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  logic                        ram_we;
  logic [SEGMENT_ID_WIDTH-1:0] ram_waddr;
  logic                        ram_wdata;
  logic                        seg_ram [SEGMENT_COUNT];
  logic                        ram_q;

  logic hs_q;
  logic rd_valid_q;
  logic pixel_on_q;
  logic pixel_on_d;
  logic vblank_q;
  logic forced_q;
  logic forced_d;
  logic overflow_q;
  logic overflow_d;

  assign fifo_wdata = '{id: seg_wr_id, value: seg_wr_value};
  assign fifo_rdata = seg_wr_t'(fifo_rdata_raw);

  segment_write_fifo #(
    .WIDTH (SEG_WR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (seg_wr),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fifo_pop  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + SEGMENT_ID_WIDTH'(1);
        if (clr_cnt_q == LAST_ID) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!fifo_empty && (vblank || fifo_full)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          ram_we    = 1'b1;
          ram_waddr = fifo_rdata.id;
          ram_wdata = fifo_rdata.value;
          // While popping, any seg_wr is accepted, so it keeps us busy.
          if (fifo_count == CW'(1) && !seg_wr) begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Port B write; port A read returns the old value on a collision.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      seg_ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    ram_q <= seg_ram[segment_id];
  end

  assign clearing   = (state_q == CLEAR);
  assign pixel_on_d = ram_q && hs_q && rd_valid_q && !clearing;

  always_comb begin
    forced_d = forced_q;
    if (vblank && !vblank_q) begin
      forced_d = 1'b0;
    end
    if (state_q == DRAIN && ram_we && !vblank) begin
      forced_d = 1'b1;
    end
  end

  assign overflow_d = overflow_q || (seg_wr && fifo_full && !fifo_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      pixel_on_q <= 1'b0;
      vblank_q   <= 1'b0;
      forced_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      hs_q       <= has_segment;
      // A read issued during CLEAR may see a not-yet-cleared cell.
      rd_valid_q <= !clearing;
      pixel_on_q <= pixel_on_d;
      vblank_q   <= vblank;
      forced_q   <= forced_d;
      overflow_q <= overflow_d;
    end
  end

  assign pixel_on     = pixel_on_q;
  assign forced_drain = forced_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_segment_state.sv
// Bench for segment_state: directed corner cases, a read-vector table,
// and randomized frames against a queue-based frame-commit model.
module tb_segment_state;

  logic       clk = 1'b0;
  logic       reset;
  logic       seg_wr;
  logic [9:0] seg_wr_id;
  logic       seg_wr_value;
  logic       vblank;
  logic [9:0] segment_id;
  logic       has_segment;
  logic       pixel_on;
  logic       clearing;
  logic       forced_drain;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segment_state #(.FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg_wr       (seg_wr),
    .seg_wr_id    (seg_wr_id),
    .seg_wr_value (seg_wr_value),
    .vblank       (vblank),
    .segment_id   (segment_id),
    .has_segment  (has_segment),
    .pixel_on     (pixel_on),
    .clearing     (clearing),
    .forced_drain (forced_drain),
    .overflow     (overflow)
  );

  typedef struct {
    logic [9:0] id;
    logic       hs;
    logic       exp;
    string      name;
  } rd_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_px(input logic [9:0] id, input logic hs,
                         input logic exp, input string name);
    segment_id  = id;
    has_segment = hs;
    step();
    step();
    check(name, 32'(pixel_on), 32'(exp));
    has_segment = 1'b0;
  endtask

  task automatic wr(input logic [9:0] id, input logic val);
    seg_wr       = 1'b1;
    seg_wr_id    = id;
    seg_wr_value = val;
    step();
    seg_wr = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (clearing && n < 2000) begin
      step();
      n++;
    end
    check(name, 32'(n), 32'd1024);
  endtask

  task automatic vblank_pulse(input int n);
    vblank = 1'b1;
    repeat (n) step();
    vblank = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rd_vec_t    vecs[9];
    bit         model[1024];
    logic [10:0] pend[$];
    bit         pipe[$];
    logic [9:0] rid;
    logic [9:0] wid;
    logic       rhs;
    logic       wv;
    int         nwr;

    vecs[0] = '{10'd37,   1'b1, 1'b1, "vec_37_lit"};
    vecs[1] = '{10'd37,   1'b0, 1'b0, "vec_37_nohs"};
    vecs[2] = '{10'd5,    1'b1, 1'b1, "vec_5_lit"};
    vecs[3] = '{10'd100,  1'b1, 1'b1, "vec_100_lit"};
    vecs[4] = '{10'd115,  1'b1, 1'b1, "vec_115_lit"};
    vecs[5] = '{10'd116,  1'b1, 1'b0, "vec_116_dropped"};
    vecs[6] = '{10'd0,    1'b1, 1'b0, "vec_0_unlit"};
    vecs[7] = '{10'd1023, 1'b1, 1'b0, "vec_1023_unlit"};
    vecs[8] = '{10'd107,  1'b1, 1'b1, "vec_107_lit"};

    reset        = 1'b1;
    seg_wr       = 1'b0;
    seg_wr_id    = '0;
    seg_wr_value = 1'b0;
    vblank       = 1'b0;
    segment_id   = '0;
    has_segment  = 1'b0;
    step();
    step();
    check("rst_pixel_on", 32'(pixel_on), 0);
    check("rst_clearing", 32'(clearing), 1);
    check("rst_forced", 32'(forced_drain), 0);
    check("rst_overflow", 32'(overflow), 0);

    // Clear length, then every segment reads unlit.
    reset = 1'b0;
    wait_clear("clear_len");
    read_px(10'd555, 1'b1, 1'b0, "post_clear_555");
    read_px(10'd1023, 1'b1, 1'b0, "post_clear_1023");

    // Write during vblank is applied promptly.
    vblank = 1'b1;
    wr(10'd37, 1'b1);
    repeat (4) step();
    vblank = 1'b0;
    step();
    read_px(10'd37, 1'b1, 1'b1, "vb_write_37");
    read_px(10'd37, 1'b0, 1'b0, "vb_write_37_nohs");

    // Active-video write is held until the next vblank.
    wr(10'd5, 1'b1);
    read_px(10'd5, 1'b1, 1'b0, "held_5_a");
    read_px(10'd5, 1'b1, 1'b0, "held_5_b");
    read_px(10'd5, 1'b1, 1'b0, "held_5_c");
    check("held_forced", 32'(forced_drain), 0);
    vblank_pulse(8);
    read_px(10'd5, 1'b1, 1'b1, "applied_5");
    check("vb_drain_forced", 32'(forced_drain), 0);

    // 16 writes fill the queue, the 17th is dropped.
    for (int i = 0; i < 16; i++) begin
      wr(10'(100 + i), 1'b1);
    end
    check("full_no_forced_yet", 32'(forced_drain), 0);
    check("full_no_ovf_yet", 32'(overflow), 0);
    wr(10'd116, 1'b1);
    check("ovf_set", 32'(overflow), 1);
    check("drain_latency", 32'(forced_drain), 0);
    step();
    check("forced_set", 32'(forced_drain), 1);
    repeat (20) step();
    check("forced_sticky", 32'(forced_drain), 1);
    vblank = 1'b1;
    step();
    check("forced_cleared", 32'(forced_drain), 0);
    check("ovf_sticky", 32'(overflow), 1);
    repeat (4) step();
    vblank = 1'b0;
    step();

    foreach (vecs[i]) begin
      read_px(vecs[i].id, vecs[i].hs, vecs[i].exp, vecs[i].name);
    end

    // Last write to an ID wins.
    wr(10'd9, 1'b1);
    wr(10'd9, 1'b0);
    vblank_pulse(8);
    read_px(10'd9, 1'b1, 1'b0, "order_9_10");
    wr(10'd9, 1'b0);
    wr(10'd9, 1'b1);
    vblank_pulse(8);
    read_px(10'd9, 1'b1, 1'b1, "order_9_01");

    // Reset with 8 entries queued discards them.
    for (int i = 0; i < 8; i++) begin
      wr(10'(200 + i), 1'b1);
    end
    reset = 1'b1;
    step();
    check("rst_q_clearing", 32'(clearing), 1);
    check("rst_q_overflow", 32'(overflow), 0);
    check("rst_q_forced", 32'(forced_drain), 0);
    step();
    reset = 1'b0;
    wait_clear("clear_len_2");
    vblank_pulse(20);
    read_px(10'd200, 1'b1, 1'b0, "flushed_200");
    read_px(10'd207, 1'b1, 1'b0, "flushed_207");
    read_px(10'd9, 1'b1, 1'b0, "recleared_9");
    check("rst_q_ovf_after", 32'(overflow), 0);

    // Random frames: writes commit only at vblank, in arrival order.
    foreach (model[i]) model[i] = 1'b0;
    for (int f = 0; f < 30; f++) begin
      nwr = 0;
      pend.delete();
      pipe.delete();
      vblank = 1'b0;
      for (int c = 0; c < 42; c++) begin
        rid = 10'($urandom_range(0, 31));
        rhs = 1'($urandom_range(0, 1));
        segment_id  = rid;
        has_segment = (c < 40) ? rhs : 1'b0;
        seg_wr = 1'b0;
        if (c < 40 && nwr < 12 && $urandom_range(0, 3) == 0) begin
          wid = 10'($urandom_range(0, 31));
          wv  = 1'($urandom_range(0, 1));
          seg_wr       = 1'b1;
          seg_wr_id    = wid;
          seg_wr_value = wv;
          pend.push_back({wid, wv});
          nwr++;
        end
        pipe.push_back(has_segment & model[rid]);
        step();
        if (pipe.size() == 2) begin
          check("rand_px", 32'(pixel_on), 32'(pipe.pop_front()));
        end
      end
      seg_wr      = 1'b0;
      has_segment = 1'b0;
      step();
      check("rand_px_tail", 32'(pixel_on), 32'(pipe.pop_front()));
      vblank = 1'b1;
      repeat (24) step();
      vblank = 1'b0;
      foreach (pend[k]) model[pend[k][10:1]] = pend[k][0];
      step();
      check("rand_forced", 32'(forced_drain), 0);
      check("rand_overflow", 32'(overflow), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
